fp_mul_result_buffer: RTL and testbench

FP_MUL_RESULT_BUFFER -- requirements
Module: fp_mul_result_buffer

---
 rtl/fp_mul_result_buffer.sv | 90 +++++++++
 tb/tb_fp_mul_result_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_result_buffer.sv
// Circular FIFO between fp_multiplier and writeback. Each entry holds the product,
// its destination tag and a class flag set that is computed when the entry is written.
module fp_mul_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [4:0]               in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [4:0]               out_rd,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              retired
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Class of an IEEE-754 single: {nan, inf, zero, subnormal}; the sign bit plays no part.
  function automatic logic [3:0] classify(input logic [DATA_W-1:0] r);
    logic [7:0]  e;
    logic [22:0] m;
    e = r[30:23];
    m = r[22:0];
    classify = {(e == 8'hFF) && (m != '0),
                (e == 8'hFF) && (m == '0),
                (e == 8'h00) && (m == '0),
                (e == 8'h00) && (m != '0)};
  endfunction

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [4:0]        mem_rd     [DEPTH];
  logic [3:0]        mem_flags  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign out_result = mem_result[rd_ptr];
  assign out_rd     = mem_rd[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];

  // Storage carries no reset; entries are only meaningful while counted by level.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_result[wr_ptr] <= in_result;
      mem_rd[wr_ptr]     <= in_rd;
      mem_flags[wr_ptr]  <= classify(in_result);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      retired <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        retired <= retired + 16'd1;
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Bench for fp_mul_result_buffer: directed scenarios followed by randomized traffic,
// all compared against a queue-based model of the buffer.
module tb_fp_mul_result_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_rd, out_rd;
  logic [3:0]  out_flags;
  logic [2:0]  level;
  logic [15:0] retired;

  fp_mul_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_flags(out_flags), .level(level), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
  } entry_t;

  entry_t      mq[$];
  logic [15:0] m_retired;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [3:0] flags_of(input logic [31:0] r);
    int unsigned e, m;
    e = (r >> 23) & 32'hFF;
    m = r & 32'h7FFFFF;
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("retired", 32'(retired), 32'(m_retired));
    if (mq.size() != 0) begin
      chk("out_result", out_result, mq[0].result);
      chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
      chk("out_flags", 32'(out_flags), 32'(flags_of(mq[0].result)));
    end
  endtask

  // One clock: decide the model's push/pop from pre-edge inputs, advance, then check.
  task automatic cycle();
    bit     do_push, do_pop;
    entry_t e;
    do_push = in_valid && (mq.size() != DEPTH) && !flush;
    do_pop  = (mq.size() != 0) && out_ready && !flush;
    e.result = in_result;
    e.rd     = in_rd;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_retired = 16'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        m_retired = m_retired + 16'd1;
      end
      if (do_push) mq.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0; reset = 0;
  endtask

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 5))
      0: return {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1: return {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
      2: return {$urandom_range(0, 1) == 1, 31'd0};
      3: return {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      4: return {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom())};
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] tbl [4];
  logic [15:0] saved;

  initial begin
    m_retired = 16'd0;
    in_result = '0; in_rd = '0;
    idle();
    reset = 1;
    cycle();
    cycle();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle();
    cycle();

    // Single push with writeback ready: visible one cycle later, then retired.
    in_valid = 1; in_result = 32'h40800000; in_rd = 5'd3; out_ready = 1;
    cycle();
    chk("r029_res", out_result, 32'h40800000);
    chk("r029_rd", 32'(out_rd), 32'd3);
    chk("r029_flags", 32'(out_flags), 32'd0);
    in_valid = 0;
    cycle();
    chk("r029_retired", 32'(retired), 32'd1);

    // Fill with special values, then drain and check the class of each.
    tbl[0] = 32'h7FC00000; tbl[1] = 32'h7F800000; tbl[2] = 32'h80000000; tbl[3] = 32'h00000001;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_result = tbl[i]; in_rd = 5'(i + 10);
      cycle();
    end
    chk("r030_full_ready", 32'(in_ready), 32'd0);
    chk("r030_full_level", 32'(level), 32'd4);

    // Full buffer: the offered push is refused while the pop proceeds.
    in_valid = 1; in_result = 32'h3F800000; in_rd = 5'd31; out_ready = 1;
    cycle();
    chk("r031_level", 32'(level), 32'd3);
    chk("r031_retired", 32'(retired), 32'd2);
    in_valid = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("r030_drained", 32'(out_valid), 32'd0);

    // Steady push+pop at level 2 with pointer wrap.
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_result = rand_fp(); in_rd = 5'(20 + i);
      cycle();
    end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_result = rand_fp(); in_rd = 5'(i);
      cycle();
      chk("r032_level", 32'(level), 32'd2);
    end

    // Flush beats push and pop; retired stays put.
    out_ready = 0;
    in_result = rand_fp(); in_rd = 5'd7;
    cycle();
    saved = retired;
    flush = 1; in_valid = 1; out_ready = 1;
    cycle();
    chk("r033_flush_level", 32'(level), 32'd0);
    chk("r033_flush_ovalid", 32'(out_valid), 32'd0);
    chk("r033_flush_retired", 32'(retired), 32'(saved));
    flush = 0; out_ready = 0;
    cycle();
    cycle();
    reset = 1; flush = 1; out_ready = 1;
    cycle();
    chk("r033_rst_level", 32'(level), 32'd0);
    chk("r033_rst_retired", 32'(retired), 32'd0);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      reset     = ($urandom_range(0, 150) == 0);
      in_result = rand_fp();
      in_rd     = 5'($urandom());
      cycle();
    end
    idle();
    out_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
